// File: rtl/tinymips_bus_pkg.sv
// Shared bus widths, I/O register offsets and STATUS bit positions for the
// TinyMIPS memory-port responder.
package tinymips_bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] OFS_OUT_DATA = 8'd0;
    localparam logic [ADDR_W-1:0] OFS_STATUS   = 8'd1;
    localparam logic [ADDR_W-1:0] OFS_TIMER    = 8'd2;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;

endpackage

// File: rtl/tinymips_out_fifo.sv
// Output FIFO for the responder's I/O region. A push is accepted when not
// full or when a pop happens in the same cycle; head reads 0 while empty.
module tinymips_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;

    assign pop_ok  = pop_i & ~empty_o & ~rst;
    assign push_ok = push_i & (~full_o | pop_ok) & ~rst;

    // Head is forced to 0 when empty so out_data is 0 after reset without
    // clearing the storage array.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // NOTE: storage is deliberately left out of reset; the pointers and count
    // alone define which entries are live, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every flop sees
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tinymips_bus_responder.sv
// TinyMIPS memory-port responder: RAM below IO_BASE, I/O (FIFO, STATUS, timer)
// from IO_BASE up, one-cycle read latency. Optional timer: TINYMIPS_TIMER_EN.
module tinymips_bus_responder
    import tinymips_bus_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] IO_BASE    = 8'hF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] addr_toRAM,
    input  logic [DATA_W-1:0] data_toRAM,
    output logic [DATA_W-1:0] data_fromRAM,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              is_io;
    logic [ADDR_W-1:0] io_ofs;
    logic              wr_ok;
    logic              ram_wr, push, status_wr, timer_wr;
    logic              pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] timer_val;

    logic [DATA_W-1:0] ram_q [2**ADDR_W];
    logic [DATA_W-1:0] ram_rdata_q;
    logic [DATA_W-1:0] io_rdata_q, io_rdata_d;
    logic              rd_ram_q;

    assign is_io  = (addr_toRAM >= IO_BASE);
    assign io_ofs = addr_toRAM - IO_BASE;
    assign wr_ok  = wrEn & ~rst;

    assign ram_wr    = wr_ok & ~is_io;
    assign push      = wr_ok & is_io & (io_ofs == OFS_OUT_DATA);
    assign status_wr = wr_ok & is_io & (io_ofs == OFS_STATUS);
    assign timer_wr  = wr_ok & is_io & (io_ofs == OFS_TIMER);

    assign pop = ~fifo_empty & out_ready;

    tinymips_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (data_toRAM),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .head_o  (out_data)
    );

    assign out_valid = ~fifo_empty;

    // A dropped push can only be a push into a full FIFO with no pop.
    always_comb begin
        ovf_d = ovf_q;
        if (status_wr) begin
            ovf_d = 1'b0;
        end else if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

`ifdef TINYMIPS_TIMER_EN
    logic [DATA_W-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_wr ? data_toRAM : timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_val = timer_q;
`else
    logic unused_timer_wr;
    assign unused_timer_wr = timer_wr;
    assign timer_val       = '0;
`endif

    always_comb begin
        io_rdata_d = '0;
        if (is_io) begin
            case (io_ofs)
                OFS_OUT_DATA: io_rdata_d = {{(DATA_W-CW){1'b0}}, fifo_count};
                OFS_STATUS: begin
                    io_rdata_d[ST_EMPTY] = fifo_empty;
                    io_rdata_d[ST_FULL]  = fifo_full;
                    io_rdata_d[ST_OVF]   = ovf_q;
                end
                OFS_TIMER:  io_rdata_d = timer_val;
                default:    io_rdata_d = '0;
            endcase
        end
    end

    // RAM kept reset-free so it maps onto block RAM; read-before-write order.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram_q[addr_toRAM] <= data_toRAM;
        end
        ram_rdata_q <= ram_q[addr_toRAM];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_rdata_q <= '0;
            rd_ram_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            io_rdata_q <= io_rdata_d;
            rd_ram_q   <= ~is_io;
            ovf_q      <= ovf_d;
        end
    end

    assign data_fromRAM = rd_ram_q ? ram_rdata_q : io_rdata_q;

endmodule

// File: tb/tb_tinymips_bus_responder.sv
// Directed self-checking bench for tinymips_bus_responder; timer expectations
// follow TINYMIPS_TIMER_EN.
module tb_tinymips_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrEn;
    logic [7:0]  addr_toRAM;
    logic [15:0] data_toRAM;
    logic [15:0] data_fromRAM;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tinymips_bus_responder #(
        .FIFO_DEPTH (4),
        .IO_BASE    (8'hF0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wrEn         (wrEn),
        .addr_toRAM   (addr_toRAM),
        .data_toRAM   (data_toRAM),
        .data_fromRAM (data_fromRAM),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive at the negedge, return at the next negedge so the
    // posedge in between has taken effect.
    task automatic cyc(input logic we, input logic [7:0] a, input logic [15:0] d);
        wrEn       = we;
        addr_toRAM = a;
        data_toRAM = d;
        @(negedge clk);
    endtask

    logic [15:0] exp_timer_a;
    logic [15:0] exp_timer_b;

    initial begin
`ifdef TINYMIPS_TIMER_EN
        exp_timer_a = 16'hFFFF;
        exp_timer_b = 16'h0000;
`else
        exp_timer_a = 16'h0000;
        exp_timer_b = 16'h0000;
`endif
        rst        = 1'b1;
        wrEn       = 1'b0;
        addr_toRAM = 8'h00;
        data_toRAM = 16'h0000;
        out_ready  = 1'b0;
        @(negedge clk);
        // Push attempted while in reset must be ignored.
        cyc(1'b1, 8'hF0, 16'h0007);
        check("reset_rdata", data_fromRAM, 16'h0000);
        check("reset_valid", {15'd0, out_valid}, 16'h0000);
        check("reset_odata", out_data, 16'h0000);
        rst = 1'b0;

        // RAM write, read, same-cycle read/write
        cyc(1'b1, 8'h10, 16'h1234);
        cyc(1'b0, 8'h10, 16'h0000);
        check("ram_read", data_fromRAM, 16'h1234);
        cyc(1'b1, 8'h10, 16'hBEEF);
        check("ram_rw_old", data_fromRAM, 16'h1234);
        cyc(1'b0, 8'h10, 16'h0000);
        check("ram_read_new", data_fromRAM, 16'hBEEF);
        cyc(1'b1, 8'h10, 16'h1234);
        check("fifo_empty_after_rst", {15'd0, out_valid}, 16'h0000);

        // Fill with consumer stalled; a push cycle reads the pre-edge count
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 8'hF0, 16'(k));
            check("push_cnt_pre", data_fromRAM, 16'(k - 1));
            if (k == 1) begin
                check("valid_rise", {15'd0, out_valid}, 16'h0001);
                check("head_first", out_data, 16'h0001);
            end
        end
        cyc(1'b0, 8'hF1, 16'h0000);
        check("status_full", data_fromRAM, 16'h0002);
        cyc(1'b1, 8'hF0, 16'h0005);
        cyc(1'b0, 8'hF1, 16'h0000);
        check("status_ovf", data_fromRAM, 16'h0006);
        cyc(1'b0, 8'hF0, 16'h0000);
        check("count_full", data_fromRAM, 16'h0004);
        check("head_stall", out_data, 16'h0001);

        // Drain
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("drain_valid", {15'd0, out_valid}, 16'h0001);
            check("drain_data", out_data, 16'(k));
            cyc(1'b0, 8'h20, 16'h0000);
        end
        check("drain_empty", {15'd0, out_valid}, 16'h0000);
        cyc(1'b0, 8'hF1, 16'h0000);
        check("status_empty_ovf", data_fromRAM, 16'h0005);
        cyc(1'b1, 8'hF1, 16'h0000);
        cyc(1'b0, 8'hF1, 16'h0000);
        check("status_ovf_clr", data_fromRAM, 16'h0001);

        // Simultaneous push/pop while full
        out_ready = 1'b0;
        for (int k = 5; k <= 8; k++) cyc(1'b1, 8'hF0, 16'(k));
        out_ready = 1'b1;
        cyc(1'b1, 8'hF0, 16'h0009);
        out_ready = 1'b0;
        cyc(1'b0, 8'hF0, 16'h0000);
        check("pp_count", data_fromRAM, 16'h0004);
        cyc(1'b0, 8'hF1, 16'h0000);
        check("pp_status", data_fromRAM, 16'h0002);
        out_ready = 1'b1;
        for (int k = 6; k <= 9; k++) begin
            check("pp_drain", out_data, 16'(k));
            cyc(1'b0, 8'h20, 16'h0000);
        end
        check("pp_empty", {15'd0, out_valid}, 16'h0000);
        out_ready = 1'b0;

        // Timer load and wrap
        cyc(1'b1, 8'hF2, 16'hFFFE);
        cyc(1'b0, 8'h20, 16'h0000);
        cyc(1'b0, 8'hF2, 16'h0000);
        check("timer_ffff", data_fromRAM, exp_timer_a);
        cyc(1'b0, 8'hF2, 16'h0000);
        check("timer_wrap", data_fromRAM, exp_timer_b);

        // Reserved I/O offset
        cyc(1'b1, 8'hF5, 16'hAAAA);
        cyc(1'b0, 8'hF5, 16'h0000);
        check("reserved_rd", data_fromRAM, 16'h0000);

        // Reset mid-operation with three entries queued and a concurrent push
        for (int k = 1; k <= 3; k++) cyc(1'b1, 8'hF0, 16'(k + 16'h0010));
        check("pre_rst_valid", {15'd0, out_valid}, 16'h0001);
        rst = 1'b1;
        cyc(1'b1, 8'hF0, 16'h0044);
        rst = 1'b0;
        check("mid_rst_valid", {15'd0, out_valid}, 16'h0000);
        check("mid_rst_odata", out_data, 16'h0000);
        check("mid_rst_rdata", data_fromRAM, 16'h0000);
        cyc(1'b0, 8'hF2, 16'h0000);
        check("timer_after_rst", data_fromRAM, 16'h0000);
        cyc(1'b0, 8'hF1, 16'h0000);
        check("mid_rst_status", data_fromRAM, 16'h0001);
        cyc(1'b0, 8'h10, 16'h0000);
        check("ram_kept", data_fromRAM, 16'h1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tinymips_bus_responder.md
# tinymips_bus_responder

Responder for the TinyMIPS CPU memory port, connected to the CPU's `wrEn`/`addr_toRAM`/`data_toRAM`/`data_fromRAM` bus and replacing the bare block RAM on that bus. It decodes the 8-bit word address into a RAM region and a small memory-mapped I/O region. The I/O region holds an output FIFO, drained by an external valid/ready consumer, and an optional free-running timer. All reads have a fixed one-cycle latency, matching what the CPU's fetch and load states expect.

## Interface
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, 2..16.
- `IO_BASE`, 8'hF0: first I/O address. RAM occupies 0x00..IO_BASE-1; I/O occupies IO_BASE..0xFF.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high; clock `clk`.
- `wrEn`  in  1: CPU write strobe, qualified by `addr_toRAM`.
- `addr_toRAM`  in  8: CPU word address, sampled every cycle.
- `data_toRAM`  in  16: CPU write data.
- `data_fromRAM`  out  16: registered read data for the address presented in the previous cycle.
- `out_valid`  out  1: FIFO head is valid.
- `out_data`  out  16: FIFO head word.
- `out_ready`  in  1: consumer accepts the head word when `out_valid & out_ready`.

## Operation
- **RAM region.** Reads are registered: `data_fromRAM <= mem[addr]` at every posedge. A write with `wrEn=1` commits at the same posedge. A read and write to the same address in one cycle returns the old data.
- **I/O map, as offsets from IO_BASE:**
  - +0 OUT_DATA. Write pushes `data_toRAM`. Read returns the pre-edge FIFO count, zero-extended.
  - +1 STATUS. Read returns {13'd0, ovf, full, empty}. Any write clears `ovf`.
  - +2 TIMER. Read returns the counter value before the edge. Write loads `data_toRAM`; the load wins over the increment.
  - +3..+15: read 0, writes ignored.
- **Push rule.** A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - A push that is not accepted is dropped and sets sticky `ovf`.
  - Push and pop in the same cycle leave the count unchanged.
- **FIFO pointers.** Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits.
- **FIFO outputs.** `out_data` is driven from the head entry. `out_valid = !empty`. `out_data` holds stable while `out_valid & !out_ready`.
- **Timer.** 16-bit, increments by 1 every cycle, wraps 0xFFFF -> 0x0000.
- **Reset.**
  - `data_fromRAM` = 0, `out_valid` = 0, `out_data` = 0.
  - FIFO count, pointers and `ovf` = 0. Timer = 0.
  - RAM contents are not cleared.
  - Reset asserted mid-transfer discards all FIFO contents. A concurrent push is ignored.

## Timing
- Read latency is exactly 1 cycle for both RAM and I/O. Address in cycle N gives data on `data_fromRAM` during cycle N+1.
- Write latency is 0 wait states; the write commits at the end of the cycle in which `wrEn` is high.
- `out_valid` rises the cycle after a push into an empty FIFO.
- A pop takes effect at the accepting edge; the next entry appears on `out_data` in the following cycle.
- STATUS and count reads reflect state before the edge. A read issued in the same cycle as a push therefore does not include that push.
- `wrEn` is ignored while `rst` is high.

## Configuration
- Macro `TINYMIPS_TIMER_EN`.
  - **Defined:** timer present as described.
  - **Undefined:** no counter flops are generated. TIMER reads return 0 and TIMER writes are ignored.

## Structure
- **Package `tinymips_bus_pkg`:**
  - I/O offset constants `OFS_OUT_DATA=0`, `OFS_STATUS=1`, `OFS_TIMER=2`.
  - STATUS bit positions `ST_EMPTY=0`, `ST_FULL=1`, `ST_OVF=2`.
  - Bus width constants ADDR_W=8, DATA_W=16.
- **Sub-module `tinymips_out_fifo`** (parameter DEPTH; push/pop/full/empty/count/head).
  - The top level owns the address decode, RAM array, read mux, `ovf` and the timer.

## Test plan
- **RAM write then read:** write 0x1234 to 0x10, then present 0x10 on the next cycle -> `data_fromRAM`=0x1234 one cycle later. Same-cycle read/write of 0x10 with 0xBEEF -> old value 0x1234 returned.
- **FIFO fill with consumer stalled:** `out_ready`=0, four writes of 1,2,3,4 to 0xF0 -> STATUS reads 0x0002 (full). A fifth write of 5 -> STATUS 0x0006 (full, ovf). Count read returns 4.
- **Drain:** raise `out_ready` -> `out_data` sequence 1,2,3,4 on consecutive cycles, then `out_valid`=0 and STATUS=0x0005 (empty, ovf). Write to 0xF1 -> STATUS=0x0001.
- **Simultaneous push/pop when full:** with `out_ready`=1 while pushing 9 -> count stays 4, ovf stays 0, 9 emerges last.
- **Timer:** write 0xFFFE to 0xF2, read 0xF2 two cycles later -> 0xFFFF. Following read -> 0x0000. With `TINYMIPS_TIMER_EN` undefined -> reads 0x0000.
- **Reset mid-operation:** FIFO holding 3 entries, `rst` for 1 cycle -> `out_valid`=0 and STATUS=0x0001. RAM word 0x10 still reads 0x1234.
